// File: rtl/wb_bram_pkg.sv
// Shared types and the burst address helper for the Wishbone BlockRAM slave.
package wb_bram_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLASSIC,
        S_BURST
    } state_t;

    // Wrap modes step only the low 2/3/4 word bits; linear steps the whole index.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input bte_t mode);
        logic [31:0] nxt;
        nxt = addr;
        case (mode)
            BTE_WRAP4:  nxt[1:0] = addr[1:0] + 2'd1;
            BTE_WRAP8:  nxt[2:0] = addr[2:0] + 3'd1;
            BTE_WRAP16: nxt[3:0] = addr[3:0] + 4'd1;
            default:    nxt = addr + 32'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wb_bram_ram.sv
// Single-port 32-bit RAM with four byte lanes and a registered read port.
module wb_bram_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // A write landing on the word being read in the same edge forwards the new bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en && be[i] && (wr_idx == rd_idx)) rdata[8*i +: 8] <= wdata[8*i +: 8];
                else                                       rdata[8*i +: 8] <= mem[rd_idx][8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 registered-feedback BlockRAM slave with incrementing/wrapping bursts
// and an optional out-of-range error response.
module wb_bram_burst
    import wb_bram_pkg::*;
#(
    parameter int mem_adr_width = 11,
    parameter bit CHECK_RANGE   = 1'b1,
    parameter bit BURST_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [3:0]  sel,
    input  logic [31:0] dat_ms,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic [31:0] dat_sm,
    output logic        ack,
    output logic        err,
    output logic        rty
);

    localparam int AW = mem_adr_width;

    state_t        state, state_next;
    logic          ack_next, err_next;
    logic [AW-1:0] burst_adr, burst_adr_next, burst_adr_inc;
    logic [AW-1:0] word_idx, rd_idx;
    logic          request, out_of_range, start_burst, beat, last_beat;
    logic          rd_en, wr_en;
    logic          unused_adr_bits;

    assign request         = cyc & stb;
    assign word_idx        = adr[AW+1:2];
    assign out_of_range    = CHECK_RANGE && (adr[31:AW+2] != '0);
    assign start_burst     = BURST_EN && (cti == CTI_INCR);
    assign beat            = stb & ack;
    assign last_beat       = (cti != CTI_INCR);
    assign burst_adr_inc   = AW'(wrap_inc(32'(burst_adr), bte_t'(bte)));
    assign wr_en           = stb & we & ack;
    assign rd_en           = ack_next;
    assign rty             = 1'b0;
    assign unused_adr_bits = ^adr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            burst_adr <= '0;
        end else begin
            state     <= state_next;
            ack       <= ack_next;
            err       <= err_next;
            burst_adr <= burst_adr_next;
        end
    end

    // The err cycle itself is not a fresh request, so one offending access gives one pulse.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (request && !err && !out_of_range)
                    state_next = start_burst ? S_BURST : S_CLASSIC;
            end
            S_CLASSIC: state_next = S_IDLE;
            S_BURST: begin
                if (!cyc || (beat && last_beat)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // burst_adr is the word of the beat currently being offered; after an accepted beat
    // the RAM is read from the advanced address so the next beat needs no wait state.
    always_comb begin
        ack_next       = 1'b0;
        err_next       = 1'b0;
        burst_adr_next = burst_adr;
        rd_idx         = word_idx;
        case (state)
            S_IDLE: begin
                if (request && !err) begin
                    if (out_of_range) begin
                        err_next = 1'b1;
                    end else begin
                        ack_next       = 1'b1;
                        burst_adr_next = word_idx;
                    end
                end
            end
            S_BURST: begin
                if (cyc) begin
                    if (beat) begin
                        if (!last_beat) begin
                            ack_next       = 1'b1;
                            burst_adr_next = burst_adr_inc;
                            rd_idx         = burst_adr_inc;
                        end
                    end else if (stb) begin
                        ack_next = 1'b1;
                        rd_idx   = burst_adr;
                    end
                end
            end
            default: ack_next = 1'b0;
        endcase
    end

    wb_bram_ram #(
        .AW(AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .wr_en  (wr_en),
        .wr_idx (word_idx),
        .be     (sel),
        .wdata  (dat_ms),
        .rdata  (dat_sm)
    );

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: classic, linear and wrap bursts, stalls, err, reset mid-burst.
module tb_wb_bram_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_ms, dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;

    int vectors     = 0;
    int miscompares = 0;

    wb_bram_burst #(
        .mem_adr_width (11),
        .CHECK_RANGE   (1'b1),
        .BURST_EN      (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cyc    (cyc),
        .stb    (stb),
        .we     (we),
        .adr    (adr),
        .sel    (sel),
        .dat_ms (dat_ms),
        .cti    (cti),
        .bte    (bte),
        .dat_sm (dat_sm),
        .ack    (ack),
        .err    (err),
        .rty    (rty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic s, input logic w, input logic [31:0] a,
                                 input logic [3:0] se, input logic [31:0] d,
                                 input logic [2:0] ct, input logic [1:0] bt);
        cyc = c; stb = s; we = w; adr = a; sel = se; dat_ms = d; cti = ct; bte = bt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idleBus();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'b000, 2'b00);
    endtask

    // One classic access: ack exactly one cycle after the strobe, then back to idle.
    task automatic classicAccess(input string tag, input logic w, input logic [31:0] a,
                                 input logic [3:0] se, input logic [31:0] d, input logic [31:0] exp_rd);
        applyStimulus(1'b1, 1'b1, w, a, se, d, 3'b000, 2'b00);
        checkOutput({tag, " ack before"}, 32'(ack), 32'd0);
        step();
        checkOutput({tag, " ack"}, 32'(ack), 32'd1);
        checkOutput({tag, " err"}, 32'(err), 32'd0);
        if (!w) checkOutput({tag, " data"}, dat_sm, exp_rd);
        step();
        idleBus();
        checkOutput({tag, " ack after"}, 32'(ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idleBus();
        step();
        step();
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset dat_sm", dat_sm, 32'h0);
        checkOutput("reset rty", 32'(rty), 32'd0);
        rst = 1'b0;
        step();

        classicAccess("cl wr full", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
        classicAccess("cl wr half", 1'b1, 32'h10, 4'h3, 32'h0000AA55, 32'h0);
        classicAccess("cl rd merged", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADAA55);
        classicAccess("cl wr sel0", 1'b1, 32'h10, 4'h0, 32'h12345678, 32'h0);
        classicAccess("cl rd sel0", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADAA55);

        for (int k = 0; k < 4; k++)
            classicAccess("fill lin", 1'b1, 32'h20 + 32'(4*k), 4'hF, 32'(k + 1), 32'h0);

        // Linear read burst, words 8..11.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 3'b010, 2'b00);
        for (int k = 0; k < 4; k++) begin
            step();
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h20 + 32'(4*k), 4'hF, 32'h0,
                          (k == 3) ? 3'b111 : 3'b010, 2'b00);
            checkOutput($sformatf("lin rd ack%0d", k), 32'(ack), 32'd1);
            checkOutput($sformatf("lin rd data%0d", k), dat_sm, 32'(k + 1));
        end
        step();
        idleBus();
        checkOutput("lin rd ack end", 32'(ack), 32'd0);

        // Wrap4 write burst from word 2: lands in words 2,3,0,1.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h08, 4'hF, 32'hA0, 3'b010, 2'b01);
        for (int k = 0; k < 4; k++) begin
            step();
            applyStimulus(1'b1, 1'b1, 1'b1, 32'(((k + 2) % 4) * 4), 4'hF, 32'hA0 + 32'(k),
                          (k == 3) ? 3'b111 : 3'b010, 2'b01);
            checkOutput($sformatf("wrap wr ack%0d", k), 32'(ack), 32'd1);
        end
        step();
        idleBus();
        checkOutput("wrap wr ack end", 32'(ack), 32'd0);
        classicAccess("wrap chk w0", 1'b0, 32'h00, 4'hF, 32'h0, 32'hA2);
        classicAccess("wrap chk w1", 1'b0, 32'h04, 4'hF, 32'h0, 32'hA3);
        classicAccess("wrap chk w2", 1'b0, 32'h08, 4'hF, 32'h0, 32'hA0);
        classicAccess("wrap chk w3", 1'b0, 32'h0C, 4'hF, 32'h0, 32'hA1);
        classicAccess("wrap chk w4", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADAA55);

        // Wrap4 read burst from word 3: words 3,0,1,2.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0C, 4'hF, 32'h0, 3'b010, 2'b01);
        for (int k = 0; k < 4; k++) begin
            step();
            applyStimulus(1'b1, 1'b1, 1'b0, 32'(((k + 3) % 4) * 4), 4'hF, 32'h0,
                          (k == 3) ? 3'b111 : 3'b010, 2'b01);
            checkOutput($sformatf("wrap rd ack%0d", k), 32'(ack), 32'd1);
            checkOutput($sformatf("wrap rd data%0d", k), dat_sm, 32'hA0 + 32'((k + 1) % 4));
        end
        step();
        idleBus();
        checkOutput("wrap rd ack end", 32'(ack), 32'd0);

        // Linear read burst with a two-cycle master stall after beat 1.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 3'b010, 2'b00);
        step();
        checkOutput("stall ack0", 32'(ack), 32'd1);
        checkOutput("stall data0", dat_sm, 32'd1);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0, 3'b010, 2'b00);
        checkOutput("stall ack1", 32'(ack), 32'd1);
        checkOutput("stall data1", dat_sm, 32'd2);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h28, 4'hF, 32'h0, 3'b010, 2'b00);
        step();
        checkOutput("stall ack idle", 32'(ack), 32'd0);
        checkOutput("stall data held", dat_sm, 32'd3);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h28, 4'hF, 32'h0, 3'b010, 2'b00);
        checkOutput("stall ack resume", 32'(ack), 32'd0);
        step();
        checkOutput("stall ack2", 32'(ack), 32'd1);
        checkOutput("stall data2", dat_sm, 32'd3);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h2C, 4'hF, 32'h0, 3'b111, 2'b00);
        checkOutput("stall ack3", 32'(ack), 32'd1);
        checkOutput("stall data3", dat_sm, 32'd4);
        step();
        idleBus();
        checkOutput("stall ack end", 32'(ack), 32'd0);

        // Out-of-range write aliasing word 0: err pulse only, RAM untouched.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0001_0000, 4'hF, 32'h12345678, 3'b000, 2'b00);
        step();
        checkOutput("range err", 32'(err), 32'd1);
        checkOutput("range ack", 32'(ack), 32'd0);
        checkOutput("range rty", 32'(rty), 32'd0);
        step();
        idleBus();
        checkOutput("range err pulse", 32'(err), 32'd0);
        checkOutput("range ack after", 32'(ack), 32'd0);
        classicAccess("range chk w0", 1'b0, 32'h00, 4'hF, 32'h0, 32'hA2);

        // Reset asserted during beat 2 of a linear write burst to words 12..15.
        for (int k = 0; k < 4; k++)
            classicAccess("fill rst", 1'b1, 32'h30 + 32'(4*k), 4'hF, 32'h11111111, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h30, 4'hF, 32'hB0, 3'b010, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step();
            applyStimulus(1'b1, 1'b1, 1'b1, 32'h30 + 32'(4*k), 4'hF, 32'hB0 + 32'(k), 3'b010, 2'b00);
            checkOutput($sformatf("rst burst ack%0d", k), 32'(ack), 32'd1);
        end
        rst = 1'b1;
        #1;
        checkOutput("rst mid ack", 32'(ack), 32'd0);
        checkOutput("rst mid err", 32'(err), 32'd0);
        checkOutput("rst mid dat_sm", dat_sm, 32'h0);
        idleBus();
        step();
        step();
        rst = 1'b0;
        step();
        classicAccess("rst chk w12", 1'b0, 32'h30, 4'hF, 32'h0, 32'hB0);
        classicAccess("rst chk w13", 1'b0, 32'h34, 4'hF, 32'h0, 32'hB1);
        classicAccess("rst chk w14", 1'b0, 32'h38, 4'hF, 32'h0, 32'h11111111);
        classicAccess("rst chk w15", 1'b0, 32'h3C, 4'hF, 32'h0, 32'h11111111);
        checkOutput("final rty", 32'(rty), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
